raizing_pcm_banker: RTL

Parametrised NMK112-style ADPCM ROM bank controller for Raizing/Toaplan sound boards. It serves CHIPS OKI M6295 (jt6295) ROM ports from a single SDRAM read port. Features: per-chip 4×64 KB bank registers, NMK112 header-table paging with a per-chip page-mask, round-robin arbitration, and per-chip one-entry data caching. It sits between the Z80 I/O decode (0xC0–0xC6 class writes) and the PCM SDRAM slot, replacing per-chip NMK112 instances and their dedicated SDRAM ports.

---
 rtl/raizing_pcm_banker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/raizing_pcm_banker.sv
// NMK112-style bank controller: several M6295 ROM ports share one SDRAM read port.
// Each chip keeps a one-byte cache tagged with its last fetched offset; misses are served round-robin.
module raizing_pcm_banker #(
    parameter int              CHIPS      = 2,
    parameter int              BANK_W     = 4,
    parameter int              AW         = 21,
    parameter logic [AW-1:0]   ROM_STRIDE = 21'h100000
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      WR,
    input  logic [$clog2(CHIPS)+1:0]  WSEL,
    input  logic [7:0]                WDATA,
    input  logic [CHIPS-1:0]          PAGE_MASK,
    input  logic [CHIPS*18-1:0]       REQ_ADDR,
    output logic [CHIPS*8-1:0]        REQ_DATA,
    output logic [CHIPS-1:0]          REQ_OK,
    output logic                      ROM_CS,
    output logic [AW-1:0]             ROM_ADDR,
    input  logic [7:0]                ROM_DATA,
    input  logic                      ROM_OK
);
    localparam int GW = (CHIPS > 1) ? $clog2(CHIPS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} st_t;

    st_t                                 state_q, state_d;
    logic [CHIPS-1:0][3:0][BANK_W-1:0]   bank_q;
    logic [CHIPS-1:0][17:0]              tag_q;
    logic [CHIPS-1:0]                    valid_q;
    logic [CHIPS-1:0][7:0]               data_q;
    logic [GW-1:0]                       rr_q, gchip_q;
    logic [17:0]                         tag_inf_q;
    logic                                kill_q;
    logic [AW-1:0]                       addr_q;

    logic [CHIPS-1:0]                    pending, wr_hit;
    logic [CHIPS-1:0][17:0]              req_a;
    logic [CHIPS-1:0][AW-1:0]            xaddr;
    logic                                gnt_any, busy, accept;
    logic [GW-1:0]                       gnt_idx;
    logic [31:0]                         wchip;
    logic                                unused_wdata;

    assign wchip        = 32'(WSEL >> 2);
    assign busy         = (state_q != IDLE);
    assign ROM_ADDR     = addr_q;
    assign unused_wdata = ^WDATA;

    for (genvar k = 0; k < CHIPS; k++) begin : g_chip
        logic [1:0] r;
        assign req_a[k]           = REQ_ADDR[18*k +: 18];
        assign REQ_OK[k]          = valid_q[k] && (tag_q[k] == req_a[k]);
        assign REQ_DATA[8*k +: 8] = data_q[k];
        assign pending[k]         = !REQ_OK[k] && !(busy && gchip_q == GW'(k));
        // wchip is compared at full width so out-of-range chip indices never hit
        assign wr_hit[k]          = WR && (wchip == 32'(k));
        // The first 1 KB holds the sample header table, paged by offset bits 9:8
        assign r        = (req_a[k] < 18'h400 && !PAGE_MASK[k]) ? req_a[k][9:8] : req_a[k][17:16];
        assign xaddr[k] = AW'(k) * ROM_STRIDE + AW'({bank_q[k][r], req_a[k][15:0]});
    end

    always_comb begin
        logic [GW-1:0] idx;
        idx     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        // Walk downward so the chip nearest rr_q is the one left standing
        for (int i = CHIPS-1; i >= 0; i--) begin
            idx = GW'((int'(rr_q) + i) % CHIPS);
            if (pending[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ROM_OK) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ROM_OK during ISSUE may belong to the previous address, so only WAIT accepts it
    always_comb begin
        ROM_CS = (state_q == ISSUE) || (state_q == WAIT);
        accept = (state_q == WAIT) && ROM_OK;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bank_q    <= '0;
            tag_q     <= '0;
            valid_q   <= '0;
            data_q    <= '0;
            rr_q      <= '0;
            gchip_q   <= '0;
            tag_inf_q <= '0;
            kill_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            if (state_q == IDLE && gnt_any) begin
                addr_q    <= xaddr[gnt_idx];
                tag_inf_q <= req_a[gnt_idx];
                gchip_q   <= gnt_idx;
                kill_q    <= wr_hit[gnt_idx];
            end else if (busy && wr_hit[gchip_q]) begin
                kill_q <= 1'b1;
            end
            if (accept) rr_q <= GW'((int'(gchip_q) + 1) % CHIPS);
            for (int k = 0; k < CHIPS; k++) begin
                if (accept && gchip_q == GW'(k)) begin
                    data_q[k]  <= ROM_DATA;
                    tag_q[k]   <= tag_inf_q;
                    valid_q[k] <= !kill_q;
                end
                // A bank write always wins over a completing fetch
                if (wr_hit[k]) begin
                    bank_q[k][WSEL[1:0]] <= WDATA[BANK_W-1:0];
                    valid_q[k]           <= 1'b0;
                end
            end
        end
    end
endmodule
